// File: rtl/cam_stim_driver_if.sv
// -----------------------------------------------------------------------------
// cam_stim_driver_if
//   Bundles every non-clock/reset signal of the CAM stimulus driver: the
//   transaction-load port, the start/busy/done control, the CAM request and
//   read-data wires, and the read-response port.
//
//   Modports
//     master : the driver itself (drives the CAM request, push_ready, busy,
//              done and the response port).
//     slave  : the environment (loads transactions, pulses start, plays the
//              CAM by returning val_o/valid_o, consumes responses).
//
//   Signal summary
//     push_valid/push_ready, push_rw_n, push_key, push_val, push_gap
//     start, busy, done
//     valid_i, rw_n, key, val_i   (CAM request, driver -> CAM)
//     val_o, valid_o              (CAM read data / hit, CAM -> driver)
//     rsp_valid, rsp_key, rsp_data, rsp_hit
//
//   Widths must match the parameters given to cam_stim_driver.
// -----------------------------------------------------------------------------
interface cam_stim_driver_if #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16,
  parameter int GAP_W = 4
);
  logic             push_valid;
  logic             push_ready;
  logic             push_rw_n;
  logic [KEY_W-1:0] push_key;
  logic [VAL_W-1:0] push_val;
  logic [GAP_W-1:0] push_gap;

  logic             start;
  logic             busy;
  logic             done;

  logic             valid_i;
  logic             rw_n;
  logic [KEY_W-1:0] key;
  logic [VAL_W-1:0] val_i;
  logic [VAL_W-1:0] val_o;
  logic             valid_o;

  logic             rsp_valid;
  logic [KEY_W-1:0] rsp_key;
  logic [VAL_W-1:0] rsp_data;
  logic             rsp_hit;

  modport master (
    input  push_valid, push_rw_n, push_key, push_val, push_gap, start,
           val_o, valid_o,
    output push_ready, busy, done, valid_i, rw_n, key, val_i,
           rsp_valid, rsp_key, rsp_data, rsp_hit
  );

  modport slave (
    output push_valid, push_rw_n, push_key, push_val, push_gap, start,
           val_o, valid_o,
    input  push_ready, busy, done, valid_i, rw_n, key, val_i,
           rsp_valid, rsp_key, rsp_data, rsp_hit
  );
endinterface

// File: rtl/cam_stim_driver.sv
// -----------------------------------------------------------------------------
// cam_stim_driver
//   Initiator end of the CAM interface. A queue of read/write transactions is
//   loaded through the push port; a start pulse makes the block issue them in
//   order, one request cycle each, followed by the per-entry idle gap. Every
//   read's CAM result (latency 1) is returned on the response port.
//
//   Ports
//     clk        clock
//     rst        asynchronous reset, active-high
//     bus        cam_stim_driver_if.master (push port, start/busy/done,
//                CAM request/read data, response port)
//     timestamp  free-running cycle counter, only with CAM_DRV_TS_EN
//
//   Optional feature
//     CAM_DRV_TS_EN : when defined, adds parameter TS_W and the timestamp
//                     output (increments every clk, wraps, resets to 0).
//
//   Timing of one run (start sampled at the edge opening cycle s):
//     cycle s         first request on the CAM (busy rises)
//     after each request, gap idle cycles, then the next request
//     last request L with gap g: DRAIN at L+g+1, DONE at L+g+2 (done=1)
//     read at cycle t: CAM answers during t+1, response visible at t+2
// -----------------------------------------------------------------------------
module cam_stim_driver #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16,
  parameter int DEPTH = 8,
  parameter int GAP_W = 4
`ifdef CAM_DRV_TS_EN
  ,
  parameter int TS_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  cam_stim_driver_if.master bus
`ifdef CAM_DRV_TS_EN
  ,
  output logic [TS_W-1:0]   timestamp
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic             rw_n;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
    logic [GAP_W-1:0] gap;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  // Queue storage and pointers
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           head;

  // FSM and registered outputs
  state_t           state_q;
  logic [GAP_W-1:0] cur_gap_q;   // gap of the request currently on the bus
  logic [GAP_W-1:0] gap_cnt_q;
  logic             busy_q, busy_d;
  logic             done_q;
  logic             push_ready_q, push_ready_d;
  logic             valid_i_q, rw_n_q;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_i_q;

  // Read response pipeline: rd_pend_q marks the cycle the CAM drives val_o
  logic             rd_pend_q;
  logic [KEY_W-1:0] rd_pend_key_q;
  logic             rsp_valid_q, rsp_hit_q;
  logic [KEY_W-1:0] rsp_key_q;
  logic [VAL_W-1:0] rsp_data_q;

  logic             push_fire, pop_fire;

  assign head = mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    push_fire = bus.push_valid && push_ready_q;
    pop_fire  = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      S_IDLE:  begin
        pop_fire = bus.start && (count_q != '0);
        if (bus.start) busy_d = 1'b1;
      end
      S_ISSUE: pop_fire = (cur_gap_q == '0) && (count_q != '0);
      S_GAP:   pop_fire = (gap_cnt_q == '0) && (count_q != '0);
      S_DONE:  busy_d = 1'b0;
      default: ;
    endcase
    count_d      = count_q + (PTR_W+1)'(push_fire) - (PTR_W+1)'(pop_fire);
    push_ready_d = !busy_d && (count_d != (PTR_W+1)'(DEPTH));
  end

  // NOTE: the queue storage has no reset; emptiness is defined by the
  // pointers and count, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= '{rw_n: bus.push_rw_n, key: bus.push_key,
                           val: bus.push_val, gap: bus.push_gap};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cur_gap_q     <= '0;
      gap_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      push_ready_q  <= 1'b1;
      valid_i_q     <= 1'b0;
      rw_n_q        <= 1'b0;
      key_q         <= '0;
      val_i_q       <= '0;
      rd_pend_q     <= 1'b0;
      rd_pend_key_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_key_q     <= '0;
      rsp_data_q    <= '0;
      rsp_hit_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      busy_q       <= busy_d;
      push_ready_q <= push_ready_d;
      if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;

      // Request bus idles at zero unless a pop below drives it
      valid_i_q <= 1'b0;
      rw_n_q    <= 1'b0;
      key_q     <= '0;
      val_i_q   <= '0;
      done_q    <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.start && (count_q == '0)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (cur_gap_q != '0) begin
            state_q   <= S_GAP;
            gap_cnt_q <= cur_gap_q - GAP_W'(1);
          end else if (!pop_fire) begin
            state_q <= S_DRAIN;
          end
        end
        S_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end else if (!pop_fire) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Issuing the head overrides whatever transition the case chose
      if (pop_fire) begin
        state_q   <= S_ISSUE;
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        cur_gap_q <= head.gap;
        valid_i_q <= 1'b1;
        rw_n_q    <= head.rw_n;
        key_q     <= head.key;
        val_i_q   <= head.rw_n ? '0 : head.val;
      end

      // CAM answers the cycle after the request; capture at the end of it
      rd_pend_q     <= valid_i_q && rw_n_q;
      rd_pend_key_q <= key_q;
      rsp_valid_q   <= rd_pend_q;
      if (rd_pend_q) begin
        rsp_key_q  <= rd_pend_key_q;
        rsp_data_q <= bus.val_o;
        rsp_hit_q  <= bus.valid_o;
      end
    end
  end

  assign bus.push_ready = push_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.valid_i    = valid_i_q;
  assign bus.rw_n       = rw_n_q;
  assign bus.key        = key_q;
  assign bus.val_i      = val_i_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_key    = rsp_key_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_hit    = rsp_hit_q;

`ifdef CAM_DRV_TS_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign timestamp = ts_q;
`endif

endmodule
